// File: rtl/mig_app_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mig_arb_pkg
// Shared definitions for the MIG application-port arbiter:
//   - MIG app_cmd encodings (write / read)
//   - arbiter FSM state encoding
//   - tag-width helper used by the top and the tag FIFO
// ---------------------------------------------------------------------------
package mig_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Width needed to hold a requester index (never below one bit).
    function automatic int tag_width(input int num_req);
        if (num_req > 1) begin
            return $clog2(num_req);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mig_app_arbiter_tag_fifo.sv
// ---------------------------------------------------------------------------
// mig_arb_tag_fifo
// Synchronous FIFO holding the requester index of every read command that
// MIG has accepted but not yet answered. Pushes into a full FIFO and pops
// from an empty FIFO are ignored; a simultaneous push and pop both apply.
//
// Ports
//   clk      in   clock (rising edge)
//   rst      in   asynchronous active-high reset, empties the FIFO
//   i_push   in   write i_din
//   i_din    in   WIDTH   requester index
//   i_pop    in   discard head entry
//   o_dout   out  WIDTH   head entry (valid while !o_empty)
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module mig_arb_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Flag decode and qualified push/pop strobes.
    always_comb begin
        o_empty   = (r_wptr == r_rptr);
        o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_push_ok = i_push & ~o_full;
        w_pop_ok  = i_pop & ~o_empty;
        o_dout    = r_mem[r_rptr[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/mig_app_arbiter.sv
// ---------------------------------------------------------------------------
// mig_app_arbiter
// Arbitrates NUM_REQ requesters onto one Xilinx MIG application interface.
// IDLE picks a winner and registers its request; ISSUE drives the command
// channel (and, for writes, the write-data channel) until MIG has accepted
// every required channel, then pulses req_ready[winner]. Read commands push
// the winner index into a tag FIFO; returned read data pops it and is
// forwarded one cycle later on rsp_valid[tag]/rsp_data.
//
// Configuration macro
//   MIG_ARB_RR_EN  defined   : round-robin, search starts after last winner
//                  undefined : fixed priority, requester 0 highest
//
// Ports
//   ui_clk, rst                  clock, asynchronous active-high reset
//   init_calib_complete          no new grant while low
//   req_valid/req_rd             per-requester valid, 1 = read
//   req_addr/req_wdata/req_wmask packed per-requester request fields
//   req_ready                    pulse: request fully accepted by MIG
//   rsp_valid/rsp_data           one-hot read-data strobe and data
//   rsp_err                      sticky: read data with no tag outstanding
//   app_en/app_cmd/app_addr/app_rdy                         MIG command
//   app_wdf_wren/app_wdf_end/app_wdf_data/app_wdf_mask/app_wdf_rdy  MIG wdata
//   app_rd_data/app_rd_data_valid                           MIG read return
// ---------------------------------------------------------------------------
module mig_app_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                           ui_clk,
    input  logic                           rst,
    input  logic                           init_calib_complete,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wmask,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           app_en,
    output logic [2:0]                     app_cmd,
    output logic [ADDR_WIDTH-1:0]          app_addr,
    input  logic                           app_rdy,
    output logic                           app_wdf_wren,
    output logic                           app_wdf_end,
    output logic [DATA_WIDTH-1:0]          app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]        app_wdf_mask,
    input  logic                           app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]          app_rd_data,
    input  logic                           app_rd_data_valid
);

    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int MASK_W = DATA_WIDTH / 8;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [TAG_W-1:0]        r_idx;
    logic                    r_rd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [MASK_W-1:0]       r_wmask;
    logic                    r_cmd_done;
    logic                    r_wdf_done;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_err;

    logic [NUM_REQ-1:0]      w_elig;
    logic                    w_found;
    logic [TAG_W-1:0]        w_win;
    logic                    w_grant;
    logic                    w_issue;
    logic                    w_cmd_acc;
    logic                    w_wdf_acc;
    logic                    w_complete;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_push;
    logic                    w_fifo_pop;
    logic [TAG_W-1:0]        w_fifo_tag;

`ifdef MIG_ARB_RR_EN
    // Index where the next search begins (one past the last winner).
    logic [TAG_W-1:0]        r_ptr;
`endif

    // Winner selection among eligible requesters; a read is only eligible
    // while the tag FIFO has room for its index.
    always_comb begin
        int idx;
        idx     = 0;
        w_elig  = req_valid & ~(req_rd & {NUM_REQ{w_fifo_full}});
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MIG_ARB_RR_EN
            idx = (int'(r_ptr) + k) % NUM_REQ;
`else
            idx = k;
`endif
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = TAG_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
        w_grant = (r_state == ST_IDLE) && init_calib_complete && w_found;
    end

    // Channel handshakes; each channel finishes independently and the
    // request completes once both (command, plus wdata for writes) are done.
    always_comb begin
        w_issue     = (r_state == ST_ISSUE);
        w_cmd_acc   = w_issue && !r_cmd_done && app_rdy;
        w_wdf_acc   = w_issue && !r_wdf_done && app_wdf_rdy;
        w_complete  = w_issue && (r_cmd_done || w_cmd_acc) && (r_wdf_done || w_wdf_acc);
        w_fifo_push = w_cmd_acc && r_rd;
        w_fifo_pop  = app_rd_data_valid && !w_fifo_empty;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_complete) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // MIG-facing and requester-facing outputs, decoded from registered state.
    always_comb begin
        app_en       = w_issue && !r_cmd_done;
        app_cmd      = (w_issue && r_rd) ? CMD_RD : CMD_WR;
        app_addr     = r_addr;
        app_wdf_wren = w_issue && !r_wdf_done;
        app_wdf_end  = w_issue && !r_wdf_done;
        app_wdf_data = r_wdata;
        app_wdf_mask = r_wmask;
        req_ready    = '0;
        if (w_complete) begin
            req_ready[r_idx] = 1'b1;
        end else begin
            req_ready = '0;
        end
        rsp_valid    = r_rsp_valid;
        rsp_data     = r_rsp_data;
        rsp_err      = r_rsp_err;
    end

    // FSM state register.
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured request and per-channel completion flags. A read has no
    // write-data phase, so its wdata channel starts out already done.
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
        end else if (w_grant) begin
            r_idx      <= w_win;
            r_rd       <= req_rd[w_win];
            r_addr     <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata    <= req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            r_wmask    <= req_wmask[int'(w_win)*MASK_W +: MASK_W];
            r_cmd_done <= 1'b0;
            r_wdf_done <= req_rd[w_win];
        end else if (w_complete) begin
            // Clear the command qualifier so app_cmd returns to CMD_WR in IDLE.
            r_rd       <= 1'b0;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_cmd_done <= 1'b1;
            end
            if (w_wdf_acc) begin
                r_wdf_done <= 1'b1;
            end
        end
    end

`ifdef MIG_ARB_RR_EN
    // Round-robin pointer moves one past each winner.
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            if (int'(w_win) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + {{(TAG_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

    // Read response path: one-cycle registered forward of MIG read data to
    // the requester named by the head tag; data with no tag is an error.
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_fifo_pop) begin
                r_rsp_valid[w_fifo_tag] <= 1'b1;
                r_rsp_data              <= app_rd_data;
            end
            if (app_rd_data_valid && w_fifo_empty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    mig_arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (ui_clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_din   (r_idx),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_tag),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_mig_app_arbiter.sv
module tb_mig_app_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic               ui_clk = 1'b0;
    logic               rst;
    logic               init_calib_complete;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_rd;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR*MW-1:0]   req_wmask;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               app_en;
    logic [2:0]         app_cmd;
    logic [AW-1:0]      app_addr;
    logic               app_rdy;
    logic               app_wdf_wren;
    logic               app_wdf_end;
    logic [DW-1:0]      app_wdf_data;
    logic [MW-1:0]      app_wdf_mask;
    logic               app_wdf_rdy;
    logic [DW-1:0]      app_rd_data;
    logic               app_rd_data_valid;

    typedef struct {
        int           idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tagq[$];
    logic exp_err;
    int   total = 0;
    int   bad   = 0;

    mig_app_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(8)
    ) dut (
        .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_rd(req_rd), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 ui_clk = ~ui_clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ui_clk);
        rst = 1'b1;
        init_calib_complete = 1'b0;
        req_valid = '0; req_rd = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        sbq.delete(); tagq.delete(); exp_err = 1'b0;
        repeat (2) @(negedge ui_clk);
        rst = 1'b0;
        init_calib_complete = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_valid[idx] = 1'b1;
        req_rd[idx]    = rd;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
        req_wmask[idx*MW +: MW] = m;
    endtask

    // One request with both MIG channels ready: IDLE cycle, then ISSUE cycle.
    task automatic issue(input int idx, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic [NR-1:0] oh;
        oh = '0; oh[idx] = 1'b1;
        @(negedge ui_clk);
        set_req(idx, rd, a, d, m);
        #1 chk("idle_app_en", app_en, 0);
        @(negedge ui_clk); #1;
        chk("iss_app_en", app_en, 1);
        chk("iss_cmd", app_cmd, rd ? 3'b001 : 3'b000);
        chk("iss_addr", app_addr, a);
        chk("iss_wren", app_wdf_wren, !rd);
        chk("iss_ready", req_ready, oh);
        if (!rd) begin
            chk("iss_wdata", app_wdf_data, d);
            chk("iss_wmask", app_wdf_mask, m);
        end
        if (rd) tagq.push_back(idx);
        @(negedge ui_clk);
        req_valid[idx] = 1'b0;
        #1 chk("post_app_en", app_en, 0);
    endtask

    // Drive one beat of MIG read data; expectation comes from the bench tag model.
    task automatic rd_return(input logic [DW-1:0] d);
        exp_t e;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b1;
        app_rd_data = d;
        if (tagq.size() > 0) begin
            e.idx = tagq.pop_front();
            e.data = d;
            sbq.push_back(e);
        end else begin
            exp_err = 1'b1;
        end
        #1 chk("rsp_lat", rsp_valid, 0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        if (sbq.size() > 0) begin
            logic [NR-1:0] oh;
            e = sbq.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            chk("rsp_valid", rsp_valid, oh);
            chk("rsp_data", rsp_data, e.data);
        end else begin
            chk("rsp_none", rsp_valid, 0);
        end
        chk("rsp_err", rsp_err, exp_err);
    endtask

    initial begin
        logic [DW-1:0] pat;
        logic [NR-1:0] exp_rdy;

        // Reset state
        rst = 1'b1;
        do_reset();
        #1;
        chk("rst_app_en", app_en, 0);
        chk("rst_app_cmd", app_cmd, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_end", app_wdf_end, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);

        // No grant while calibration incomplete
        @(negedge ui_clk);
        init_calib_complete = 1'b0;
        set_req(0, 1'b0, 28'h40, 128'h1, 16'h0);
        repeat (3) begin
            @(negedge ui_clk); #1 chk("calib_hold", app_en, 0);
        end
        init_calib_complete = 1'b1;
        @(negedge ui_clk); #1;
        chk("calib_en", app_en, 1);
        chk("calib_ready", req_ready, 2'b01);
        @(negedge ui_clk);
        req_valid = '0;

        // Single write from requester 0
        issue(0, 1'b0, 28'h100, {4{32'hDEADBEEF}}, 16'h00F0);

        // Read from requester 1, data returned ten cycles later
        issue(1, 1'b1, 28'h200, '0, '0);
        repeat (8) @(negedge ui_clk);
        rd_return({16{8'hA5}});

        // Write with wdata accepted first and command accepted two cycles later
        @(negedge ui_clk);
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        set_req(0, 1'b0, 28'h300, 128'h55, 16'h0);
        @(negedge ui_clk); #1;
        chk("split1_en", app_en, 1);
        chk("split1_wren", app_wdf_wren, 1);
        chk("split1_ready", req_ready, 0);
        @(negedge ui_clk);
        app_wdf_rdy = 1'b0;
        #1;
        chk("split2_en", app_en, 1);
        chk("split2_wren", app_wdf_wren, 0);
        chk("split2_ready", req_ready, 0);
        @(negedge ui_clk);
        app_rdy = 1'b1;
        #1;
        chk("split3_en", app_en, 1);
        chk("split3_ready", req_ready, 2'b01);
        @(negedge ui_clk);
        req_valid = '0; app_wdf_rdy = 1'b1;
        #1 chk("split4_en", app_en, 0);

        // Both requesters continuously valid
        do_reset();
        @(negedge ui_clk);
        set_req(0, 1'b0, 28'h10, 128'h10, 16'h0);
        set_req(1, 1'b0, 28'h20, 128'h20, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ui_clk); #1;
`ifdef MIG_ARB_RR_EN
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
            chk("arb_ready", req_ready, exp_rdy);
            @(negedge ui_clk);
        end
        req_valid = '0;

        // Tag FIFO fills at eight outstanding reads; ninth waits
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b1, AW'(28'h1000 + i), '0, '0);
        end
        @(negedge ui_clk);
        set_req(0, 1'b1, 28'h2000, '0, '0);
        repeat (4) begin
            @(negedge ui_clk); #1 chk("full_hold", app_en, 0);
        end
        rd_return(128'hC0DE_0000);
        @(negedge ui_clk); #1;
        chk("ninth_en", app_en, 1);
        chk("ninth_cmd", app_cmd, 3'b001);
        chk("ninth_ready", req_ready, 2'b01);
        tagq.push_back(0);
        @(negedge ui_clk);
        req_valid = '0;
        for (int i = 1; i <= 8; i++) begin
            pat = 128'hC0DE_0000 + DW'(i);
            rd_return(pat);
        end

        // Read data with nothing outstanding
        rd_return(128'hBAD);

        // Reset in the middle of ISSUE
        @(negedge ui_clk);
        app_rdy = 1'b0;
        set_req(0, 1'b0, 28'h500, 128'h5, 16'h0);
        @(negedge ui_clk); #1;
        chk("mid_en", app_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_en", app_en, 0);
        chk("mid_rst_wren", app_wdf_wren, 0);
        chk("mid_rst_cmd", app_cmd, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        @(negedge ui_clk);
        req_valid = '0; rst = 1'b0; app_rdy = 1'b1;
        @(negedge ui_clk); #1;
        chk("after_rst_en", app_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
